// File: rtl/uart_pkg.sv
// uart_pkg: UART state type, divider floor and parity helper shared by tx and rx
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
    localparam int UART_DIV_MIN = 2;
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
endpackage

// File: rtl/uart_tx_frontend_if.sv
// uart_tx_frontend_if: byte valid/ready handshake into the transmitter
interface uart_tx_frontend_if;
    logic       tx_valid_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o;
    modport master (output tx_valid_i, output tx_data_i, input tx_ready_o);
    modport slave (input tx_valid_i, input tx_data_i, output tx_ready_o);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: power-of-two synchronous FIFO with occupancy count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     srst_n_i,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_level;
    logic             w_push, w_pop;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end
endmodule

// File: rtl/uart_tx_frontend.sv
// uart_tx_frontend: FIFO-buffered 8-bit LSB-first UART transmitter with runtime divider
module uart_tx_frontend import uart_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          srst_n_i,
    input  logic [DIV_WIDTH-1:0]          div_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          stop2_i,
    uart_tx_frontend_if.slave             s_if,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    uart_tx_state_t       r_state, w_state_n;
    logic [DIV_WIDTH-1:0] r_div, r_timer, w_div_clamped;
    logic [2:0]           r_bit, w_bit_n;
    logic [7:0]           r_shift, w_fifo_data;
    logic                 r_par_en, r_par, r_stop2, r_tx, r_rdy;
    logic                 w_tx_n, w_wrap, w_pop, w_full, w_empty;
    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .srst_n_i (srst_n_i),
        .i_push   (s_if.tx_valid_i & s_if.tx_ready_o),
        .i_data   (s_if.tx_data_i),
        .i_pop    (w_pop),
        .o_data   (w_fifo_data),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (fifo_level_o)
    );
    assign s_if.tx_ready_o = srst_n_i & r_rdy & ~w_full;
    assign busy_o          = ~w_empty | (r_state != IDLE);
    assign tx_o            = r_tx;
    assign w_div_clamped   = (div_i < DIV_WIDTH'(UART_DIV_MIN)) ? DIV_WIDTH'(UART_DIV_MIN) : div_i;
    assign w_wrap          = r_timer == r_div - DIV_WIDTH'(1);
    // tx_o is registered from the next-state decision so each bit edge is glitch-free
    always_comb begin
        w_state_n = r_state;
        w_bit_n   = r_bit;
        w_tx_n    = r_tx;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_n = w_empty;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_n = START;
                end
            end
            START: if (w_wrap) begin
                w_state_n = DATA;
                w_bit_n   = '0;
                w_tx_n    = r_shift[0];
            end
            DATA: if (w_wrap) begin
                if (r_bit == 3'd7) begin
                    w_state_n = r_par_en ? PARITY : STOP;
                    w_bit_n   = '0;
                    w_tx_n    = r_par_en ? r_par : 1'b1;
                end else begin
                    w_bit_n = r_bit + 3'd1;
                    w_tx_n  = r_shift[1];
                end
            end
            PARITY: if (w_wrap) begin
                w_state_n = STOP;
                w_bit_n   = '0;
                w_tx_n    = 1'b1;
            end
            STOP: if (w_wrap) begin
                if (r_stop2 && !r_bit[0]) w_bit_n = 3'd1;
                else begin
                    w_pop     = ~w_empty;
                    w_state_n = w_empty ? IDLE : START;
                    w_tx_n    = w_empty;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_bit   <= '0;
            r_timer <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_tx    <= w_tx_n;
            r_bit   <= w_bit_n;
            r_timer <= (r_state == IDLE || w_wrap) ? '0 : r_timer + DIV_WIDTH'(1);
            r_rdy   <= 1'b1;
        end
    end
    // Frame configuration is captured at pop so mid-frame input changes wait for the next frame
    always_ff @(posedge clk_i) begin
        if (w_pop) begin
            r_shift  <= w_fifo_data;
            r_div    <= w_div_clamped;
            r_par_en <= parity_en_i;
            r_par    <= uart_parity(w_fifo_data, parity_odd_i);
            r_stop2  <= stop2_i;
        end else if (r_state == DATA && w_wrap) begin
            r_shift <= r_shift >> 1;
        end
    end
endmodule

// File: doc/uart_tx_frontend.md
# uart_tx_frontend

Byte-oriented UART transmitter: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serializes them as 8-bit LSB-first frames with a runtime bit divider, optional parity and 1 or 2 stop bits. It is the transmit side of the debug UART path. It drives the SoC `tx_o` line toward the host, complementing the receive path that decodes host commands on `rx_i`. Benches reuse it as a serial stimulus source.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO entries (power of two, ≥2)
- `DIV_WIDTH`, 16: width of bit-period divider input
- `clk_i`  in  1  system clock
- `srst_n_i`  in  1  reset; one clock, reset is synchronous and active-low
- `div_i`  in  DIV_WIDTH  clocks per bit; values <2 treated as 2 (868 = 115200 baud at 100 MHz)
- `parity_en_i`  in  1  insert parity bit after data
- `parity_odd_i`  in  1  1 = odd parity, 0 = even
- `stop2_i`  in  1  1 = two stop bits
- `tx_valid_i`  in  1  byte offered
- `tx_data_i`  in  8  byte payload
- `tx_ready_o`  out  1  FIFO not full; transfer on `tx_valid_i & tx_ready_o` at rising edge
- `tx_o`  out  1  serial line, idle high
- `busy_o`  out  1  FIFO non-empty or frame in progress
- `fifo_level_o`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx_o`=1. If FIFO non-empty: pop the head into the shift register. Latch `div_i` (clamped), parity mode and stop count. Go to START.
- START: `tx_o`=0 for one bit period, then DATA.
- DATA: 8 bits, LSB first, one bit period each. Bit counter 0..7. After bit 7, go to PARITY if parity is enabled, else STOP.
- PARITY: `tx_o` = XOR of the 8 data bits, inverted when odd parity is selected. One bit period, then STOP.
- STOP: `tx_o`=1 for 1 or 2 bit periods. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Bit timer: counts 0..div−1 and wraps. A state or bit change happens only on wrap.
- Configuration changes mid-frame have no effect until the next frame.
- FIFO:
  - Push and pop in the same cycle leave the level unchanged.
  - A push is impossible when full, because `tx_ready_o`=0.
  - A pop happens only when the FIFO is non-empty.
- Reset (sampled high→low at any edge, including mid-frame):
  - Frame aborted, FIFO flushed.
  - Outputs at the next edge: `tx_o`=1, FSM=IDLE, `fifo_level_o`=0, `busy_o`=0.
  - `tx_ready_o`=0 while `srst_n_i`=0, and 1 from the first edge after release.

## Timing
- Byte accepted at edge k into an empty FIFO with FSM idle:
  - edge k+1: popped, enters START;
  - `tx_o` is low from edge k+1. Latency is 1 clock.
- Each bit lasts exactly div clocks (registered `tx_o`, no glitches).
- Frame length is div × (10 + parity_en + stop2) clocks.
- Back-to-back frames: the next start bit begins on the edge that ends the last stop bit.
- `tx_ready_o`, `fifo_level_o` and `busy_o` are registered-state derived and valid the cycle after the edge that changes them.
- Capacity: FIFO_DEPTH bytes buffered plus 1 byte in the shift register.

## Structure
- Package `uart_pkg`:
  - `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DIV_MIN`=2;
  - `uart_parity(data, odd)` function.
  - The receive side reuses this package.
- Sub-module `uart_sync_fifo` (params WIDTH, DEPTH): synchronous FIFO with the same reset, outputs full, empty and level.
- Top: FSM, bit timer, bit counter, shift register, config latches.

## Test plan
- div=4, no parity, 1 stop, send 0x55 → `tx_o` shows 0,1,0,1,0,1,0,1,0,1, each held 4 clocks, 40 clocks total. `tx_o` falls 1 clock after the accept edge.
- Parity:
  - div=4, parity even, send 0x03 → parity bit 0, frame 44 clocks.
  - Parity odd, send 0x03 → parity bit 1.
  - stop2=1 → stop held 8 clocks.
- FIFO_DEPTH=4, hold `tx_valid_i`=1 with 0x10..0x17 and div=4 →
  - 5 bytes accepted before `tx_ready_o` drops;
  - frames contiguous with no idle gap;
  - bytes emitted in order;
  - `busy_o` falls after the last stop bit.
- Assert `srst_n_i`=0 during DATA bit 3 with 3 bytes queued → next edge `tx_o`=1, `fifo_level_o`=0, `busy_o`=0. No further frames after release.
- div=868, random 256-byte stream through a bit-level UART checker at 115200 baud, 100 MHz clock → all bytes match, no framing errors.
- div_i=0 or 1 → bits last 2 clocks. Changing `div_i` mid-frame → current frame unchanged, next frame uses the new value.
